// File: rtl/vp_pkg.sv
// Shared types for the value-predictor feedback path: queue entry layout, lane count and
// a saturating counter helper used by the optional statistics (VP_FB_STATS_EN).
package vp_pkg;

    localparam int unsigned VP_NUM_LANES = 2;

    typedef struct packed {
        logic [31:1] pc;
        logic [31:0] result;
        logic        conf;
    } vp_pred_entry_t;

    function automatic logic [31:0] vp_sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + 33'(b);
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/vp_fb_fifo.sv
// Two-write / two-read circular queue of pending predictions. Up to two entries are written
// and up to two retired per cycle; the caller guarantees push/pop counts never over/underflow.
module vp_fb_fifo
    import vp_pkg::*;
#(
    parameter int unsigned P_DEPTH = 8,
    localparam int unsigned PtrW = $clog2(P_DEPTH),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic [1:0]           push_n_i,
    input  vp_pred_entry_t [1:0] push_data_i,
    input  logic [1:0]           pop_n_i,
    output vp_pred_entry_t       head_o,
    output vp_pred_entry_t       head1_o,
    output logic [CntW-1:0]      count_o
);

    vp_pred_entry_t mem_q [P_DEPTH];
    vp_pred_entry_t mem_d [P_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q + PtrW'(pop_n_i);
        wr_ptr_d = wr_ptr_q + PtrW'(push_n_i);
        count_d  = count_q + CntW'(push_n_i) - CntW'(pop_n_i);
        if (push_n_i != 2'd0) mem_d[wr_ptr_q] = push_data_i[0];
        if (push_n_i == 2'd2) mem_d[wr_ptr_q + PtrW'(1)] = push_data_i[1];
        if (clear_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload needs no reset: count_q gates every read.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign head1_o = mem_q[rd_ptr_q + PtrW'(1)];
    assign count_o = count_q;

endmodule

// File: rtl/vp_fb_gen.sv
// Value-predictor feedback generator: queues E1 predictions and validates them in order
// against writeback. Optional counters under `VP_FB_STATS_EN`.
module vp_fb_gen
    import vp_pkg::*;
#(
    parameter int unsigned P_DEPTH    = 8,
    parameter int unsigned P_NUM_PRED = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0][31:1] pred_pc_e1_i,
    input  logic [1:0][31:0] pred_result_e1_i,
    input  logic [1:0]       pred_conf_e1_i,
    input  logic [1:0]       pred_valid_e1_i,
    input  logic [1:0]       pred_en_e1_i,
    input  logic [1:0][31:1] wb_pc_i,
    input  logic [1:0][31:0] wb_result_i,
    input  logic [1:0]       wb_valid_i,
    input  logic             flush_i,
    output logic [1:0][31:1] fb_pc_o,
    output logic [1:0][31:0] fb_actual_o,
    output logic [1:0]       fb_mispredict_o,
    output logic [1:0]       fb_conf_o,
    output logic [1:0]       fb_valid_o,
    output logic             ovf_o
`ifdef VP_FB_STATS_EN
    ,
    output logic [31:0]      stat_hit_o,
    output logic [31:0]      stat_mispred_o,
    output logic [31:0]      stat_drop_o
`endif
);

    localparam int unsigned CntW = $clog2(P_DEPTH) + 1;

    vp_pred_entry_t [1:0] push_data;
    vp_pred_entry_t       head, head1, ent1;
    logic [CntW-1:0]      count, free_slots;
    logic [1:0]           push_mask, n_push, n_pop, push_n, pop_n, match, mis;
    logic                 push_ok;

    logic [1:0][31:1] fb_pc_q, fb_pc_d;
    logic [1:0][31:0] fb_actual_q, fb_actual_d;
    logic [1:0]       fb_mis_q, fb_mis_d, fb_conf_q, fb_conf_d, fb_valid_q, fb_valid_d;
    logic             ovf_q, ovf_d;

    // Compress pushing lanes so the older one always lands in the first free slot.
    always_comb begin
        push_mask    = pred_valid_e1_i & pred_en_e1_i;
        n_push       = {1'b0, push_mask[0]} + {1'b0, push_mask[1]};
        push_data[1] = '{pc: pred_pc_e1_i[1], result: pred_result_e1_i[1],
                         conf: pred_conf_e1_i[1]};
        push_data[0] = push_mask[0] ?
                       '{pc: pred_pc_e1_i[0], result: pred_result_e1_i[0],
                         conf: pred_conf_e1_i[0]} : push_data[1];
    end

    // Only entries present at cycle start (count) are candidates for matching.
    always_comb begin
        match[0]   = wb_valid_i[0] && (count != '0) && (head.pc == wb_pc_i[0]);
        ent1       = match[0] ? head1 : head;
        match[1]   = wb_valid_i[1] && (match[0] ? (count >= CntW'(2)) : (count != '0))
                     && (ent1.pc == wb_pc_i[1]);
        mis[0]     = head.result != wb_result_i[0];
        mis[1]     = ent1.result != wb_result_i[1];
        n_pop      = {1'b0, match[0]} + {1'b0, match[1]};
        free_slots = CntW'(P_DEPTH) - count + CntW'(n_pop);
        push_ok    = CntW'(n_push) <= free_slots;
        push_n     = (flush_i || !push_ok) ? 2'd0 : n_push;
        pop_n      = flush_i ? 2'd0 : n_pop;
    end

    vp_fb_fifo #(
        .P_DEPTH(P_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (flush_i),
        .push_n_i   (push_n),
        .push_data_i(push_data),
        .pop_n_i    (pop_n),
        .head_o     (head),
        .head1_o    (head1),
        .count_o    (count)
    );

    always_comb begin
        fb_pc_d     = fb_pc_q;
        fb_actual_d = fb_actual_q;
        fb_mis_d    = fb_mis_q;
        fb_conf_d   = fb_conf_q;
        fb_valid_d  = flush_i ? 2'b00 : match;
        ovf_d       = !flush_i && !push_ok;
        for (int i = 0; i < VP_NUM_LANES; i++) begin
            if (!flush_i && match[i]) begin
                fb_pc_d[i]     = wb_pc_i[i];
                fb_actual_d[i] = wb_result_i[i];
                fb_mis_d[i]    = mis[i];
                fb_conf_d[i]   = (i == 0) ? head.conf : ent1.conf;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fb_pc_q     <= '0;
            fb_actual_q <= '0;
            fb_mis_q    <= '0;
            fb_conf_q   <= '0;
            fb_valid_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            fb_pc_q     <= fb_pc_d;
            fb_actual_q <= fb_actual_d;
            fb_mis_q    <= fb_mis_d;
            fb_conf_q   <= fb_conf_d;
            fb_valid_q  <= fb_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign fb_pc_o         = fb_pc_q;
    assign fb_actual_o     = fb_actual_q;
    assign fb_mispredict_o = fb_mis_q;
    assign fb_conf_o       = fb_conf_q;
    assign fb_valid_o      = fb_valid_q;
    assign ovf_o           = ovf_q;

`ifdef VP_FB_STATS_EN
    logic [31:0] stat_hit_q, stat_hit_d, stat_mis_q, stat_mis_d, stat_drop_q, stat_drop_d;
    logic [1:0]  hit_v, mis_v;

    always_comb begin
        hit_v       = fb_valid_d & ~fb_mis_d;
        mis_v       = fb_valid_d & fb_mis_d;
        stat_hit_d  = vp_sat_add(stat_hit_q, {1'b0, hit_v[0]} + {1'b0, hit_v[1]});
        stat_mis_d  = vp_sat_add(stat_mis_q, {1'b0, mis_v[0]} + {1'b0, mis_v[1]});
        stat_drop_d = vp_sat_add(stat_drop_q, ovf_d ? n_push : 2'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_hit_q  <= '0;
            stat_mis_q  <= '0;
            stat_drop_q <= '0;
        end else begin
            stat_hit_q  <= stat_hit_d;
            stat_mis_q  <= stat_mis_d;
            stat_drop_q <= stat_drop_d;
        end
    end

    assign stat_hit_o     = stat_hit_q;
    assign stat_mispred_o = stat_mis_q;
    assign stat_drop_o    = stat_drop_q;
`endif

endmodule

// File: tb/tb_vp_fb_gen.sv
// Scoreboard bench for vp_fb_gen: a queue model predicts each cycle's feedback/overflow,
// expectations are queued at drive time and compared one cycle later.
module tb_vp_fb_gen;

    localparam int unsigned Depth = 8;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [1:0][31:1] pred_pc_e1_i;
    logic [1:0][31:0] pred_result_e1_i;
    logic [1:0]       pred_conf_e1_i, pred_valid_e1_i, pred_en_e1_i;
    logic [1:0][31:1] wb_pc_i;
    logic [1:0][31:0] wb_result_i;
    logic [1:0]       wb_valid_i;
    logic             flush_i;
    logic [1:0][31:1] fb_pc_o;
    logic [1:0][31:0] fb_actual_o;
    logic [1:0]       fb_mispredict_o, fb_conf_o, fb_valid_o;
    logic             ovf_o;
`ifdef VP_FB_STATS_EN
    logic [31:0]      stat_hit_o, stat_mispred_o, stat_drop_o;
`endif

    vp_fb_gen #(
        .P_DEPTH   (Depth),
        .P_NUM_PRED(2)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .pred_pc_e1_i    (pred_pc_e1_i),
        .pred_result_e1_i(pred_result_e1_i),
        .pred_conf_e1_i  (pred_conf_e1_i),
        .pred_valid_e1_i (pred_valid_e1_i),
        .pred_en_e1_i    (pred_en_e1_i),
        .wb_pc_i         (wb_pc_i),
        .wb_result_i     (wb_result_i),
        .wb_valid_i      (wb_valid_i),
        .flush_i         (flush_i),
        .fb_pc_o         (fb_pc_o),
        .fb_actual_o     (fb_actual_o),
        .fb_mispredict_o (fb_mispredict_o),
        .fb_conf_o       (fb_conf_o),
        .fb_valid_o      (fb_valid_o),
        .ovf_o           (ovf_o)
`ifdef VP_FB_STATS_EN
        ,
        .stat_hit_o      (stat_hit_o),
        .stat_mispred_o  (stat_mispred_o),
        .stat_drop_o     (stat_drop_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:1] pc;
        logic [31:0] res;
        logic        conf;
    } m_ent_t;

    typedef struct {
        logic [1:0]       v;
        logic [1:0]       mis;
        logic [1:0]       conf;
        logic [1:0][31:1] pc;
        logic [1:0][31:0] act;
        logic             ovf;
    } exp_t;

    m_ent_t mq[$];
    exp_t   exp_q[$];
    exp_t   hold;
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_outputs(input exp_t e);
        check_eq("fb_valid", 64'(fb_valid_o), 64'(e.v));
        check_eq("ovf", 64'(ovf_o), 64'(e.ovf));
        check_eq("fb_mispredict", 64'(fb_mispredict_o), 64'(e.mis));
        check_eq("fb_conf", 64'(fb_conf_o), 64'(e.conf));
        check_eq("fb_pc", 64'(fb_pc_o), 64'(e.pc));
        check_eq("fb_actual", 64'(fb_actual_o), 64'(e.act));
    endtask

    // One clock: drive inputs, predict with the model, then compare after the edge.
    task automatic step(input logic [1:0] pvld, input logic [1:0] pen,
                        input logic [1:0][31:1] ppc, input logic [1:0][31:0] pres,
                        input logic [1:0] pconf, input logic [1:0] wv,
                        input logic [1:0][31:1] wpc, input logic [1:0][31:0] wres,
                        input logic fl);
        exp_t   e, got_e;
        m_ent_t np[$];
        int     avail, idx;
        pred_valid_e1_i  = pvld;
        pred_en_e1_i     = pen;
        pred_pc_e1_i     = ppc;
        pred_result_e1_i = pres;
        pred_conf_e1_i   = pconf;
        wb_valid_i       = wv;
        wb_pc_i          = wpc;
        wb_result_i      = wres;
        flush_i          = fl;
        e     = hold;
        e.v   = 2'b00;
        e.ovf = 1'b0;
        if (fl) begin
            mq.delete();
        end else begin
            avail = mq.size();
            idx   = 0;
            for (int l = 0; l < 2; l++) begin
                if (wv[l] && avail > idx && mq[idx].pc == wpc[l]) begin
                    e.v[l]    = 1'b1;
                    e.pc[l]   = wpc[l];
                    e.act[l]  = wres[l];
                    e.mis[l]  = (mq[idx].res != wres[l]);
                    e.conf[l] = mq[idx].conf;
                    idx++;
                end
            end
            for (int l = 0; l < 2; l++)
                if (pvld[l] && pen[l]) np.push_back('{pc: ppc[l], res: pres[l], conf: pconf[l]});
            repeat (idx) void'(mq.pop_front());
            if (np.size() > Depth - mq.size()) e.ovf = 1'b1;
            else foreach (np[k]) mq.push_back(np[k]);
        end
        hold = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got_e = exp_q.pop_front();
        check_outputs(got_e);
    endtask

    task automatic idle();
        step(2'b00, 2'b00, '0, '0, 2'b00, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic push1(input logic [31:1] pc, input logic [31:0] res, input logic conf);
        step(2'b01, 2'b01, {31'h0, pc}, {32'h0, res}, {1'b0, conf}, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic push2(input logic [31:1] pc0, input logic [31:1] pc1);
        step(2'b11, 2'b11, {pc1, pc0}, {32'(pc1) ^ 32'h55, 32'(pc0) ^ 32'h55}, 2'b10,
             2'b00, '0, '0, 1'b0);
    endtask

    // Retire everything left in the model, two heads per cycle where possible.
    task automatic drain();
        logic [1:0][31:1] wpc;
        logic [1:0][31:0] wres;
        logic [1:0]       wv;
        int               guard;
        guard = 0;
        while (mq.size() > 0 && guard < 4 * Depth) begin
            wv = 2'b00;
            wpc = '0;
            wres = '0;
            for (int l = 0; l < 2; l++) begin
                if (mq.size() > l) begin
                    wv[l]   = 1'b1;
                    wpc[l]  = mq[l].pc;
                    wres[l] = mq[l].res ^ 32'($urandom_range(0, 1));
                end
            end
            step(2'b00, 2'b00, '0, '0, 2'b00, wv, wpc, wres, 1'b0);
            guard++;
        end
        check_eq("drain_done", 64'(mq.size()), 64'd0);
    endtask

    initial begin
        logic [1:0][31:1] wpc;
        logic [1:0][31:0] wres;
        logic [1:0]       wv, pv, pe;
        int               k, pushed, iter;
        exp_t             zero_e;

        zero_e = '{v: 2'b00, mis: 2'b00, conf: 2'b00, pc: '0, act: '0, ovf: 1'b0};
        hold   = zero_e;
        rst_i = 1'b1;
        pred_valid_e1_i = '0; pred_en_e1_i = '0; pred_pc_e1_i = '0; pred_result_e1_i = '0;
        pred_conf_e1_i = '0; wb_valid_i = '0; wb_pc_i = '0; wb_result_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs(zero_e);
        rst_i = 1'b0;

        // Single push then matching writeback
        push1(31'h100, 32'd5, 1'b1);
        step(2'b00, 2'b00, '0, '0, 2'b00, 2'b01, {31'h0, 31'h100}, {32'h0, 32'd5}, 1'b0);
        check_eq("q_empty_1", 64'(mq.size()), 64'd0);

        // Two lanes, lane1 mispredicts
        step(2'b11, 2'b11, {31'h204, 31'h200}, {32'd9, 32'd7}, 2'b01, 2'b00, '0, '0, 1'b0);
        step(2'b00, 2'b00, '0, '0, 2'b00, 2'b11, {31'h204, 31'h200}, {32'd8, 32'd7}, 1'b0);
        check_eq("mis_pattern", 64'(fb_mispredict_o), 64'b10);

        // Valid without enable must not enqueue
        step(2'b01, 2'b00, {31'h0, 31'h500}, '0, 2'b00, 2'b00, '0, '0, 1'b0);
        step(2'b00, 2'b00, '0, '0, 2'b00, 2'b01, {31'h0, 31'h500}, '0, 1'b0);

        // Fill to 7, overflow, then push 2 with one concurrent pop reaches 8
        push2(31'h400, 31'h404);
        push2(31'h408, 31'h40C);
        push2(31'h410, 31'h414);
        push1(31'h418, 32'h18, 1'b0);
        push2(31'h41C, 31'h420);
        check_eq("ovf_pulse", 64'(ovf_o), 64'd1);
        step(2'b11, 2'b11, {31'h424, 31'h41C}, {32'h24, 32'h1C}, 2'b11,
             2'b01, {31'h0, 31'h400}, {32'h0, 32'h400 ^ 32'h55}, 1'b0);
        check_eq("ovf_clear", 64'(ovf_o), 64'd0);
        check_eq("q_full", 64'(mq.size()), 64'(Depth));
        push1(31'h428, 32'h28, 1'b1);
        drain();

        // Unpredicted lane0, lane1 matches head
        push1(31'h300, 32'h33, 1'b1);
        step(2'b00, 2'b00, '0, '0, 2'b00, 2'b11, {31'h300, 31'h2FC}, {32'h33, 32'h1}, 1'b0);
        check_eq("lane1_only", 64'(fb_valid_o), 64'b10);

        // Flush with 4 entries plus push and matching wb
        push2(31'h600, 31'h604);
        push2(31'h608, 31'h60C);
        step(2'b11, 2'b11, {31'h614, 31'h610}, '0, 2'b00,
             2'b01, {31'h0, 31'h600}, '0, 1'b1);
        step(2'b00, 2'b00, '0, '0, 2'b00, 2'b11, {31'h604, 31'h600}, '0, 1'b0);
        idle();

        // Randomised fill/drain across pointer wrap
        pushed = 0;
        iter = 0;
        while (pushed < 3 * Depth && iter < 200) begin
            pv = 2'($urandom_range(0, 3));
            pe = 2'($urandom_range(0, 3)) | pv;
            wv = 2'b00;
            wpc = {31'h7FFF0, 31'h7FFF0};
            wres = '0;
            k = 0;
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 2) != 0) begin
                    wv[l] = 1'b1;
                    if (mq.size() > k && $urandom_range(0, 4) != 0) begin
                        wpc[l]  = mq[k].pc;
                        wres[l] = mq[k].res ^ 32'($urandom_range(0, 1));
                        k++;
                    end
                end
            end
            if (mq.size() + 2 <= Depth) pushed += $countones(pv & pe);
            step(pv, pe, {31'h1004 + 31'(8 * iter), 31'h1000 + 31'(8 * iter)},
                 {32'($urandom), 32'($urandom)}, 2'($urandom_range(0, 3)), wv, wpc, wres, 1'b0);
            iter++;
        end
        drain();

        // Reset mid-operation clears queue and outputs
        push2(31'h700, 31'h704);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        mq.delete();
        hold = zero_e;
        check_outputs(zero_e);
        step(2'b00, 2'b00, '0, '0, 2'b00, 2'b01, {31'h0, 31'h700}, '0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vp_fb_gen.md
Name: vp_fb_gen

Overview:
- Feedback generator: the validation end of the value-predictor interface.
- Captures E1 predictions (pc, result, conf) into an in-order queue and matches them against writeback results in program order.
- Drives the predictor's fb_* feedback port: fb_pc, fb_actual, fb_mispredict, fb_conf, fb_valid.
- Sits between the core's E1/writeback stages and vp_wrapper.

Parameters:
- P_DEPTH, 8, queue entries (power of 2, >=4).
- P_NUM_PRED, 2, lanes per cycle (fixed 2; other values unsupported).

Ports:
- clk_i  in  1  main clock
- rst_i  in  1  synchronous active-high reset
- pred_pc_e1_i  in  [1:0][31:1]  PC of E1 prediction
- pred_result_e1_i  in  [1:0][31:0]  predicted value
- pred_conf_e1_i  in  [1:0]  prediction confidence
- pred_valid_e1_i  in  [1:0]  prediction qualifier
- pred_en_e1_i  in  [1:0]  prediction consumed by core; capture only when valid&en
- wb_pc_i  in  [1:0][31:1]  writeback PC, lane0 older
- wb_result_i  in  [1:0][31:0]  actual execution result
- wb_valid_i  in  [1:0]  writeback qualifier
- flush_i  in  1  pipeline flush; clears queue
- fb_pc_o  out  [1:0][31:1]  feedback PC
- fb_actual_o  out  [1:0][31:0]  actual result
- fb_mispredict_o  out  [1:0]  stored prediction != actual
- fb_conf_o  out  [1:0]  stored confidence
- fb_valid_o  out  [1:0]  feedback qualifier
- ovf_o  out  1  one-cycle pulse: push dropped for lack of space

Behaviour:
- Reset: queue empty (rd/wr ptr=0, count=0); all outputs 0.
- Push: lanes with pred_valid_e1_i&pred_en_e1_i enqueue; lane0 before lane1. Number of lanes to push n = popcount (0..2).
- Full rule: if free slots (P_DEPTH-count after this cycle's pops) < n, push nothing; ovf_o=1 next cycle. No partial push.
- Match, lane0: wb_valid_i[0] and queue non-empty and head.pc==wb_pc_i[0] -> pop head, generate feedback on lane0. Otherwise no pop, no feedback (instruction was unpredicted).
- Match, lane1: compared against head+1 if lane0 popped, else head. Same rule. Max 2 pops/cycle.
- Pops see only entries present at cycle start; a same-cycle push is never popped.
- Feedback is registered, 1-cycle latency after wb. fb_pc_o=wb_pc, fb_actual_o=wb_result, fb_mispredict_o=(entry.result!=wb_result), fb_conf_o=entry.conf, fb_valid_o=1 for that lane. Non-matching lanes: fb_valid_o=0; other fb fields hold.
- Simultaneous push+pop: count_next = count + n_push - n_pop. Pointers wrap modulo P_DEPTH.
- flush_i dominates: queue cleared, no push, no pop, fb_valid_o=0 next cycle, ovf_o=0.
- Reset mid-operation behaves as flush plus all outputs zeroed.

Optional Feature:
- Macro VP_FB_STATS_EN.
- Defined: adds outputs stat_hit_o, stat_mispred_o, stat_drop_o (32-bit each, saturating).
  - stat_hit_o increments per fb_valid lane with mispredict=0.
  - stat_mispred_o increments per fb_valid lane with mispredict=1.
  - stat_drop_o increments by n on overflow.
  - Counters cleared by rst_i only.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- vp_pkg: typedef vp_pred_entry_t {pc[31:1], result[31:0], conf}; constant VP_NUM_LANES=2.
- Sub-module vp_fb_fifo: 2-write/2-read circular queue.
  - Interfaces: push count, pop count, head/head+1 read, count/free, clear.
- Matching and feedback register logic stay in vp_fb_gen.

Test Plan:
- Push lane0 pc=0x100, result=5, conf=1. Next cycle wb lane0 pc=0x100, result=5 -> fb_valid_o=01, fb_mispredict_o=0, fb_conf_o[0]=1; queue empty.
- Push 2 lanes pc=0x200/0x204, results 7/9. Then wb both lanes, results 7/8 -> fb_valid_o=11, fb_mispredict_o=10.
- Queue holds 7 entries; push 2 lanes -> nothing enqueued, ovf_o=1 one cycle. Same case with a concurrent single pop -> 2 lanes accepted, count=8.
- Head pc=0x300; wb lane0 pc=0x2FC (unpredicted), lane1 pc=0x300 -> fb_valid_o=10 (lane1 only), head popped.
- flush_i with 4 entries plus concurrent push and matching wb -> count=0, fb_valid_o=0, ovf_o=0; later wb of old pc yields no feedback.
- Fill/drain 3*P_DEPTH entries across pointer wrap -> every feedback matches its push in order.
